cov_stim_mon: RTL and testbench

- Stimulus driver and result monitor for the three-input pattern detector / 3-cycle pulse block in the exp4 coverage lab.
- Drives a/b/c through all 8 combinations and checks the detector outputs out1/out2.
- Counts out3 pulses and accumulates a per-combination hit bitmap, so one start/done run proves full input coverage in hardware.
- Sits beside the detector in the lab top level and owns the detector's input side.

---
 rtl/cov_pkg.sv | 19 +
 rtl/cov_out3_period_chk.sv | 49 ++++
 rtl/cov_stim_mon.sv | 157 +++++++++++++++
 tb/tb_cov_stim_mon.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cov_pkg.sv
// Shared types, constants and expected-value helpers for the exp4 coverage
// stimulus/monitor block.
package cov_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam int VEC_W       = 3;
  localparam int NUM_VEC     = 8;
  localparam int OUT3_PERIOD = 3;

  function automatic logic exp_out1(input logic [VEC_W-1:0] vec);
    return &vec;
  endfunction

  function automatic logic exp_out2(input logic [VEC_W-1:0] vec);
    return vec == 3'b110;
  endfunction

endpackage

// File: rtl/cov_out3_period_chk.sv
// out3 pulse-spacing checker: flags any pulse whose distance from the previous
// pulse is not OUT3_PERIOD. Only built when COV_OUT3_PERIOD_CHECK_EN is defined.
`ifdef COV_OUT3_PERIOD_CHECK_EN
module cov_out3_period_chk
  import cov_pkg::*;
(
  input  logic CLK,
  input  logic RSTn,
  input  logic clr_i,
  input  logic en_i,
  input  logic pulse_i,
  output logic viol_o
);

  localparam int GAP_W = 3;

  logic             seen_q, seen_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  // gap_q counts low cycles since the last pulse, so a correct period shows PERIOD-1
  always_comb begin
    seen_d = seen_q;
    gap_d  = gap_q;
    viol_o = en_i & pulse_i & seen_q & (gap_q != GAP_W'(OUT3_PERIOD - 1));
    if (clr_i) begin
      seen_d = 1'b0;
      gap_d  = '0;
    end else if (en_i) begin
      if (pulse_i) begin
        seen_d = 1'b1;
        gap_d  = '0;
      end else if (gap_q != '1) begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      seen_q <= 1'b0;
      gap_q  <= '0;
    end else begin
      seen_q <= seen_d;
      gap_q  <= gap_d;
    end
  end

endmodule
`endif

// File: rtl/cov_stim_mon.sv
// Sweeps a/b/c through all 8 vectors, checks out1/out2, counts out3 pulses and
// records a coverage bitmap. COV_OUT3_PERIOD_CHECK_EN adds out3 period checking.
module cov_stim_mon
  import cov_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int PASSES      = 1,
  parameter int ERR_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             out1,
  input  logic             out2,
  input  logic             out3,
  output logic             busy,
  output logic             done,
  output logic [7:0]       hit_map,
  output logic             cov_full,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] out3_cnt
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   abc_q, abc_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic [NUM_VEC-1:0] hit_q, hit_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_w;
  logic               mism;
  logic               period_viol;
  logic [1:0]         err_inc;
  logic [ERR_W+1:0]   err_sum;

  assign busy_w = (state_q == DRIVE) || (state_q == SAMPLE);

`ifdef COV_OUT3_PERIOD_CHECK_EN
  cov_out3_period_chk u_period_chk (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr_i   ((state_q == IDLE) && start),
    .en_i    (busy_w),
    .pulse_i (out3),
    .viol_o  (period_viol)
  );
`else
  assign period_viol = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    pass_d  = pass_q;
    hit_d   = hit_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    mism    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          pass_d  = '0;
          hit_d   = '0;
          err_d   = '0;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          hold_d  = '0;
          state_d = SAMPLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      SAMPLE: begin
        hit_d[vec_q] = 1'b1;
        mism  = (out1 != exp_out1(vec_q)) || (out2 != exp_out2(vec_q));
        vec_d = vec_q + 1'b1;
        if (vec_q == VEC_W'(NUM_VEC - 1)) begin
          if (pass_q == PASS_W'(PASSES - 1)) begin
            state_d = DONE;
          end else begin
            state_d = DRIVE;
            pass_d  = pass_q + 1'b1;
          end
        end else begin
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (busy_w && out3 && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // A sample mismatch and a period violation in one cycle add 2, saturating
    err_inc = {1'b0, mism} + {1'b0, period_viol};
    err_sum = {2'b00, err_q} + {{ERR_W{1'b0}}, err_inc};
    if (err_inc != 2'd0) begin
      err_d = (err_sum[ERR_W+1:ERR_W] != 2'b00) ? '1 : err_sum[ERR_W-1:0];
    end

    abc_d = ((state_d == DRIVE) || (state_d == SAMPLE)) ? vec_d : '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      vec_q   <= '0;
      abc_q   <= '0;
      hold_q  <= '0;
      pass_q  <= '0;
      hit_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      abc_q   <= abc_d;
      hold_q  <= hold_d;
      pass_q  <= pass_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a        = abc_q[2];
  assign b        = abc_q[1];
  assign c        = abc_q[0];
  assign busy     = busy_w;
  assign done     = (state_q == DONE);
  assign hit_map  = hit_q;
  assign cov_full = &hit_q;
  assign err_cnt  = err_q;
  assign out3_cnt = cnt_q;

endmodule

// File: tb/tb_cov_stim_mon.sv
// Bench for cov_stim_mon: a detector model drives out1/out2/out3, a run-index
// model predicts every output each cycle, and directed runs pin the totals.
module tb_cov_stim_mon;

  localparam int H = 2;
  localparam int P = 1;
  localparam int N = P * 8 * (H + 1);

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic        a, b, c, busy, done, cov_full;
  logic [7:0]  hit_map, err_cnt;
  logic [15:0] out3_cnt;
  logic        sa, sb, sc, sbusy, sdone, scov;
  logic [7:0]  shit;
  logic [1:0]  serr;
  logic [15:0] scnt;
  logic        out1, out2, out3;
  int          fault = 0;
  logic        out3_force = 1'b0;
  logic [1:0]  ph;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  cov_stim_mon #(.HOLD_CYCLES(H), .PASSES(P), .ERR_W(8), .CNT_W(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .a(a), .b(b), .c(c),
    .out1(out1), .out2(out2), .out3(out3), .busy(busy), .done(done),
    .hit_map(hit_map), .cov_full(cov_full), .err_cnt(err_cnt), .out3_cnt(out3_cnt)
  );

  cov_stim_mon #(.HOLD_CYCLES(H), .PASSES(P), .ERR_W(2), .CNT_W(16)) dut_sat (
    .CLK(CLK), .RSTn(RSTn), .start(start), .a(sa), .b(sb), .c(sc),
    .out1(out1), .out2(out2), .out3(out3), .busy(sbusy), .done(sdone),
    .hit_map(shit), .cov_full(scov), .err_cnt(serr), .out3_cnt(scnt)
  );

  // Detector: combinational out1/out2, out3 one pulse every 3 cycles; faults override
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) ph <= 2'd0;
    else       ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
  end
  assign out1 = (fault == 1) ? 1'b0 : (a & b & c);
  assign out2 = (fault == 2) ? 1'b1 : (a & b & ~c);
  assign out3 = (fault == 3) ? out3_force : (ph == 2'd2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_k is the index of the current busy cycle (-1 idle, N = done cycle)
  int       m_k = -1;
  int       m_err = 0;
  int       m_cnt = 0;
  logic [7:0] m_hit = 8'h00;
  bit       m_seen = 1'b0;
  int       m_last = 0;
  int       m_add, m_v;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_k = -1; m_err = 0; m_cnt = 0; m_hit = 8'h00; m_seen = 1'b0;
    end else if (m_k < 0) begin
      if (start) begin
        m_k = 0; m_err = 0; m_cnt = 0; m_hit = 8'h00; m_seen = 1'b0;
      end
    end else if (m_k < N) begin
      m_add = 0;
      if (out3 === 1'b1) begin
        if (m_cnt < 65535) m_cnt++;
`ifdef COV_OUT3_PERIOD_CHECK_EN
        if (m_seen && (m_k - m_last) != 3) m_add++;
        m_seen = 1'b1;
        m_last = m_k;
`endif
      end
      if (m_k % (H + 1) == H) begin
        m_v = (m_k / (H + 1)) % 8;
        m_hit[m_v] = 1'b1;
        if (out1 !== (m_v == 7) || out2 !== (m_v == 6)) m_add++;
      end
      m_err += m_add;
      m_k++;
    end else begin
      m_k = -1;
    end
  end

  logic       e_busy;
  logic [2:0] e_abc;
  always @(negedge CLK) begin
    if (cmp_en) begin
      e_busy = (m_k >= 0) && (m_k < N);
      e_abc  = e_busy ? 3'((m_k / (H + 1)) % 8) : 3'd0;
      chk("busy", busy, e_busy);
      chk("done", done, m_k == N);
      chk("abc", {a, b, c}, e_abc);
      chk("hit_map", hit_map, m_hit);
      chk("cov_full", cov_full, m_hit == 8'hFF);
      chk("err_cnt", err_cnt, (m_err > 255) ? 255 : m_err);
      chk("out3_cnt", out3_cnt, m_cnt);
      chk("err_cnt_w2", serr, (m_err > 3) ? 3 : m_err);
    end
  end

  task automatic run(input int flt, input int restart_at, input int rst_at,
                     output int nb, output int nd);
    fault = flt;
    out3_force = 1'b0;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        break;
      end
      start = (nb == restart_at);
      if (flt == 3) out3_force = (nb == 4) || (nb == 5);
      if (nb == rst_at) begin
        RSTn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_abc", {a, b, c}, 0);
        chk("abort_hit", hit_map, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_cnt", out3_cnt, 0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
    out3_force = 1'b0;
  endtask

  task automatic after_done();
    @(posedge CLK); #1;
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  int nb, nd, late_done;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abc", {a, b, c}, 0);
    chk("rst_hit", hit_map, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_cnt", out3_cnt, 0);
    RSTn = 1'b1;
    cmp_en = 1'b1;
    @(posedge CLK); #1;

    run(0, -1, -1, nb, nd);
    chk("good_busy_cycles", nb, 24);
    chk("good_done", nd, 1);
    chk("good_hit", hit_map, 8'hFF);
    chk("good_cov_full", cov_full, 1);
    chk("good_err", err_cnt, 0);
    chk("good_out3_cnt", out3_cnt, 8);
    after_done();
    $display("run good: busy=%0d done=%0d hit=%h err=%0d out3_cnt=%0d", nb, nd, hit_map, err_cnt, out3_cnt);

    run(1, -1, -1, nb, nd);
    chk("out1_s0_done", nd, 1);
    chk("out1_s0_err", err_cnt, 1);
    chk("out1_s0_hit", hit_map, 8'hFF);
    after_done();
    $display("run out1 stuck0: err=%0d hit=%h", err_cnt, hit_map);

    run(2, -1, -1, nb, nd);
    chk("out2_s1_done", nd, 1);
    chk("out2_s1_err", err_cnt, 7);
    chk("out2_s1_hit", hit_map, 8'hFF);
    chk("out2_s1_err_w2", serr, 3);
    after_done();
    $display("run out2 stuck1: err=%0d err_w2=%0d", err_cnt, serr);

    run(0, 10, -1, nb, nd);
    chk("restart_busy_cycles", nb, 24);
    chk("restart_done", nd, 1);
    chk("restart_err", err_cnt, 0);
    after_done();
    $display("run restart@10: busy=%0d done=%0d", nb, nd);

    run(0, -1, 12, nb, nd);
    chk("abort_no_done", nd, 0);
    late_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      if (done || busy) late_done++;
    end
    chk("abort_quiet", late_done, 0);
    $display("run reset@12: done=%0d later_activity=%0d", nd, late_done);

    run(0, -1, -1, nb, nd);
    chk("fresh_busy_cycles", nb, 24);
    chk("fresh_done", nd, 1);
    chk("fresh_hit", hit_map, 8'hFF);
    chk("fresh_err", err_cnt, 0);
    after_done();
    $display("run fresh: busy=%0d done=%0d err=%0d", nb, nd, err_cnt);

    run(3, -1, -1, nb, nd);
    chk("out3_pair_done", nd, 1);
    chk("out3_pair_cnt", out3_cnt, 2);
`ifdef COV_OUT3_PERIOD_CHECK_EN
    chk("out3_pair_err", err_cnt, 1);
`else
    chk("out3_pair_err", err_cnt, 0);
`endif
    after_done();
    $display("run out3 pair: out3_cnt=%0d err=%0d", out3_cnt, err_cnt);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
